// File: rtl/pe_arr.sv
// pe_arr: output-stationary ROWS x COLS systolic multiply-accumulate array.
// Activations shift right, weights shift down, a fire wavefront gates accumulation.
module pe_arr #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fire,
    input  logic [7:0]  in_w      [0:COLS-1],
    input  logic [7:0]  in_a      [0:ROWS-1],
    output logic [31:0] outs      [0:ROWS*COLS-1],
    output logic        outvalids [0:ROWS*COLS-1]
);

    logic [7:0]  r_a   [0:ROWS-1][0:COLS-1];
    logic [7:0]  r_w   [0:ROWS-1][0:COLS-1];
    logic        r_v   [0:ROWS-1][0:COLS-1];
    logic [31:0] r_acc [0:ROWS-1][0:COLS-1];
    logic        r_ov  [0:ROWS-1][0:COLS-1];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0]  w_a_in;
            logic [7:0]  w_w_in;
            logic        w_v_in;
            logic [15:0] w_prod;

            if (c == 0) begin : g_a_edge
                assign w_a_in = in_a[r];
            end else begin : g_a_link
                assign w_a_in = r_a[r][c-1];
            end

            if (r == 0) begin : g_w_edge
                assign w_w_in = in_w[c];
            end else begin : g_w_link
                assign w_w_in = r_w[r-1][c];
            end

            // The wavefront runs down column 0, then right along each row.
            if (r == 0 && c == 0) begin : g_v_src
                assign w_v_in = fire;
            end else if (c == 0) begin : g_v_down
                assign w_v_in = r_v[r-1][0];
            end else begin : g_v_right
                assign w_v_in = r_v[r][c-1];
            end

            assign w_prod = {8'd0, w_a_in} * {8'd0, w_w_in};

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_a[r][c]   <= 8'd0;
                    r_w[r][c]   <= 8'd0;
                    r_v[r][c]   <= 1'b0;
                    r_acc[r][c] <= 32'd0;
                    r_ov[r][c]  <= 1'b0;
                end else begin
                    r_a[r][c] <= w_a_in;
                    r_w[r][c] <= w_w_in;
                    r_v[r][c] <= w_v_in;
                    if (w_v_in) begin
                        r_ov[r][c] <= 1'b0;
                        if (r_v[r][c]) begin
                            r_acc[r][c] <= r_acc[r][c] + {16'd0, w_prod};
                        end else begin
                            r_acc[r][c] <= {16'd0, w_prod};
                        end
                    end else if (r_v[r][c]) begin
                        r_ov[r][c] <= 1'b1;
                    end
                end
            end

            assign outs[r*COLS+c]      = r_acc[r][c];
            assign outvalids[r*COLS+c] = r_ov[r][c];
        end
    end

endmodule

// File: tb/tb_pe_arr.sv
// tb_pe_arr: randomized self-checking bench for pe_arr.
// Expected values come from matrix arithmetic and a history-based PE model.
module tb_pe_arr;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int NPE  = ROWS * COLS;
    localparam int HMAX = 256;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fire = 1'b0;
    logic [7:0]  in_w      [0:COLS-1];
    logic [7:0]  in_a      [0:ROWS-1];
    logic [31:0] outs      [0:NPE-1];
    logic        outvalids [0:NPE-1];

    int checks = 0;
    int failures = 0;

    logic [7:0] h_a [0:HMAX-1][0:ROWS-1];
    logic [7:0] h_w [0:HMAX-1][0:COLS-1];
    logic       h_f [0:HMAX-1];
    int         hlen = 0;

    pe_arr #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .fire      (fire),
        .in_w      (in_w),
        .in_a      (in_a),
        .outs      (outs),
        .outvalids (outvalids)
    );

    always #5 clk = ~clk;

    // Records what the coming edge will sample, then advances one cycle.
    task automatic step();
        if (rstn && hlen < HMAX) begin
            h_f[hlen] = fire;
            for (int r = 0; r < ROWS; r++) h_a[hlen][r] = in_a[r];
            for (int c = 0; c < COLS; c++) h_w[hlen][c] = in_w[c];
        end
        if (rstn) hlen++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        for (int r = 0; r < ROWS; r++) in_a[r] = 8'($urandom);
        for (int c = 0; c < COLS; c++) in_w[c] = 8'($urandom);
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] w);
        for (int r = 0; r < ROWS; r++) in_a[r] = a;
        for (int c = 0; c < COLS; c++) in_w[c] = w;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        fire = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        hlen = 0;
    endtask

    function automatic logic f_at(int t);
        return (t >= 0) ? h_f[t] : 1'b0;
    endfunction

    function automatic logic [7:0] a_at(int t, int r);
        return (t >= 0) ? h_a[t][r] : 8'd0;
    endfunction

    function automatic logic [7:0] w_at(int t, int c);
        return (t >= 0) ? h_w[t][c] : 8'd0;
    endfunction

    // PE(r,c) sees fire delayed r+c, in_a[r] delayed c, in_w[c] delayed r.
    task automatic model_pe(input int r, input int c,
                            output logic [31:0] acc, output logic ov);
        logic       vi;
        logic       vr;
        logic [31:0] p;
        acc = 32'd0;
        ov  = 1'b0;
        for (int t = 0; t < hlen; t++) begin
            vi = f_at(t - r - c);
            vr = f_at(t - r - c - 1);
            p  = 32'(a_at(t - c, r)) * 32'(w_at(t - r, c));
            if (vi) begin
                acc = vr ? acc + p : p;
                ov  = 1'b0;
            end else if (vr) begin
                ov = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] acc;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fire = 1'($urandom);
            rand_inputs();
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NPE; i++) begin
            checks++;
            if (outs[i] !== 32'd0 || outvalids[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold idx=%0d got=%0d/%0b exp=0/0",
                         i, outs[i], outvalids[i]);
            end
        end
        rstn = 1'b1;
        hlen = 0;
        fire = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_inputs(8'(1 + $urandom_range(0, 254)), 8'(1 + $urandom_range(0, 254)));
            step();
        end
        fire = 1'b0;
        step();
        acc = outs[0];
        checks++;
        if (acc === 32'd0) begin
            failures++;
            $display("FAIL reset_prefill pe0 got=%0d exp=nonzero", acc);
        end
        #3;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NPE; i++) begin
            checks++;
            if (outs[i] !== 32'd0 || outvalids[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_async idx=%0d got=%0d/%0b exp=0/0",
                         i, outs[i], outvalids[i]);
            end
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        hlen = 0;
    endtask

    task automatic test_uniform();
        int d;
        do_reset();
        for (int k = 0; k <= ROWS + COLS + 4; k++) begin
            fire = (k < 4);
            for (int r = 0; r < ROWS; r++)
                in_a[r] = (k >= r && k < r + 4) ? 8'd2 : 8'($urandom);
            for (int c = 0; c < COLS; c++)
                in_w[c] = (k >= c && k < c + 4) ? 8'd3 : 8'($urandom);
            step();
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    d = r + c;
                    checks++;
                    if (outvalids[r*COLS+c] !== (k >= d + 4)) begin
                        failures++;
                        $display("FAIL uniform_valid k=%0d pe(%0d,%0d) got=%0b exp=%0b",
                                 k, r, c, outvalids[r*COLS+c], (k >= d + 4));
                    end
                end
            end
        end
        for (int i = 0; i < NPE; i++) begin
            checks++;
            if (outs[i] !== 32'd24) begin
                failures++;
                $display("FAIL uniform_acc idx=%0d got=%0d exp=24", i, outs[i]);
            end
        end
    endtask

    task automatic test_ramp();
        logic [31:0] acc;
        logic        ov;
        do_reset();
        set_inputs(8'd0, 8'd1);
        repeat (2) step();
        fire = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_inputs(8'(k + 1), 8'd1);
            step();
        end
        fire = 1'b0;
        set_inputs(8'd10, 8'd1);
        repeat (ROWS + COLS + 2) step();
        checks++;
        if (outs[0] !== 32'd55) begin
            failures++;
            $display("FAIL ramp_pe00 got=%0d exp=55", outs[0]);
        end
        checks++;
        if (outs[1] !== 32'd55) begin
            failures++;
            $display("FAIL ramp_pe01 got=%0d exp=55", outs[1]);
        end
        checks++;
        if (outs[COLS] !== 32'd64) begin
            failures++;
            $display("FAIL ramp_pe10 got=%0d exp=64", outs[COLS]);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                model_pe(r, c, acc, ov);
                checks++;
                if (outs[r*COLS+c] !== acc || outvalids[r*COLS+c] !== ov) begin
                    failures++;
                    $display("FAIL ramp_model pe(%0d,%0d) got=%0d/%0b exp=%0d/%0b",
                             r, c, outs[r*COLS+c], outvalids[r*COLS+c], acc, ov);
                end
            end
        end
    endtask

    task automatic test_matrix();
        logic [7:0]  ma [0:ROWS-1][0:7];
        logic [7:0]  mw [0:7][0:COLS-1];
        logic [31:0] dot;
        int          kk;
        for (int trial = 0; trial < 3; trial++) begin
            kk = $urandom_range(3, 8);
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < 8; k++) ma[r][k] = 8'($urandom);
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < COLS; c++) mw[k][c] = 8'($urandom);
            for (int k = 0; k <= kk + ROWS + COLS - 2; k++) begin
                fire = (k < kk);
                for (int r = 0; r < ROWS; r++)
                    in_a[r] = (k >= r && k - r < kk) ? ma[r][k-r] : 8'($urandom);
                for (int c = 0; c < COLS; c++)
                    in_w[c] = (k >= c && k - c < kk) ? mw[k-c][c] : 8'($urandom);
                step();
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    dot = 32'd0;
                    for (int k = 0; k < kk; k++)
                        dot += 32'(ma[r][k]) * 32'(mw[k][c]);
                    checks++;
                    if (outs[r*COLS+c] !== dot || outvalids[r*COLS+c] !== 1'b1) begin
                        failures++;
                        $display("FAIL matrix K=%0d pe(%0d,%0d) got=%0d/%0b exp=%0d/1",
                                 kk, r, c, outs[r*COLS+c], outvalids[r*COLS+c], dot);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] pat;
        logic [31:0] acc;
        logic        ov;
        pat = {20'd0, 20'b01011111100111101110};
        do_reset();
        for (int k = 0; k < 40; k++) begin
            fire = pat[k];
            rand_inputs();
            step();
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    model_pe(r, c, acc, ov);
                    checks++;
                    if (outs[r*COLS+c] !== acc || outvalids[r*COLS+c] !== ov) begin
                        failures++;
                        $display("FAIL b2b k=%0d pe(%0d,%0d) got=%0d/%0b exp=%0d/%0b",
                                 k, r, c, outs[r*COLS+c], outvalids[r*COLS+c], acc, ov);
                    end
                end
            end
        end
    endtask

    task automatic test_wrap();
        localparam int N = 66100;
        logic [63:0] big;
        logic [31:0] wrapv;
        logic [31:0] eacc;
        logic        eov;
        int          d;
        big   = 64'(N) * 64'd65025;
        wrapv = big[31:0];
        do_reset();
        set_inputs(8'd255, 8'd255);
        repeat (ROWS + COLS) step();
        fire = 1'b1;
        repeat (N) step();
        for (int j = 0; j <= ROWS + COLS + 4; j++) begin
            fire = (j >= 1 && j <= 3);
            step();
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    d = r + c;
                    if (j >= d) begin
                        if (j == d) begin
                            eacc = wrapv;
                            eov  = 1'b1;
                        end else if (j <= d + 3) begin
                            eacc = 32'(j - d) * 32'd65025;
                            eov  = 1'b0;
                        end else begin
                            eacc = 32'd3 * 32'd65025;
                            eov  = 1'b1;
                        end
                        checks++;
                        if (outs[r*COLS+c] !== eacc || outvalids[r*COLS+c] !== eov) begin
                            failures++;
                            $display("FAIL wrap j=%0d pe(%0d,%0d) got=%0d/%0b exp=%0d/%0b",
                                     j, r, c, outs[r*COLS+c], outvalids[r*COLS+c],
                                     eacc, eov);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] acc;
        logic        ov;
        do_reset();
        fire = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            step();
        end
        #3;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NPE; i++) begin
            checks++;
            if (outs[i] !== 32'd0 || outvalids[i] !== 1'b0) begin
                failures++;
                $display("FAIL midreset_clear idx=%0d got=%0d/%0b exp=0/0",
                         i, outs[i], outvalids[i]);
            end
        end
        fire = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        hlen = 0;
        set_inputs(8'd1, 8'd1);
        fire = 1'b1;
        repeat (3) step();
        fire = 1'b0;
        repeat (ROWS + COLS) step();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                model_pe(r, c, acc, ov);
                checks++;
                if (outs[r*COLS+c] !== 32'd3 || outvalids[r*COLS+c] !== 1'b1 ||
                    acc !== 32'd3 || ov !== 1'b1) begin
                    failures++;
                    $display("FAIL midreset_burst pe(%0d,%0d) got=%0d/%0b exp=3/1",
                             r, c, outs[r*COLS+c], outvalids[r*COLS+c]);
                end
            end
        end
    endtask

    initial begin
        set_inputs(8'd0, 8'd0);
        test_reset();
        test_uniform();
        test_ramp();
        test_matrix();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
